// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the memory-access pipeline stage: bus widths,
// write-back select codes, CSR command bit positions, the store state
// machine encoding and the layout of the execute-to-memory bus.
// Optional feature macro used by consumers: MEM_ALIGN_CHECK_EN.
package cpu_pkg;

    localparam int EXE_MEM_BUS_W = 187;
    localparam int MEM_WB_BUS_W  = 70;
    localparam int MEM_ID_BUS_W  = 38;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC4 = 3'd2;
    localparam logic [2:0] WB_CSR = 3'd3;

    // Bit positions inside the one-hot csr_cmd field
    localparam int CSR_W = 3;
    localparam int CSR_S = 2;
    localparam int CSR_C = 1;
    localparam int CSR_E = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WREQ  = 2'd1,
        S_WDONE = 2'd2
    } storeState_e;

    // First member is the most significant slice of the 187-bit bus
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] wb_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1_data;
        logic [31:0] mem_rd_data;
    } exeMemBus_t;

    // A memory access whose address is not word aligned
    function automatic logic isMisaligned(input exeMemBus_t b);
        return (b.mem_we || b.mem_re) && (b.alu_result[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/csr_rmw.sv
// csr_rmw
// Combinational CSR read-modify-write value.
// Ports:
//   csr_cmd_i   one-hot command {W, S, C, E}
//   csr_rdata_i current CSR value
//   op1_data_i  source operand
//   csr_wdata_o value to write back into the CSR (0 when no write command)
module csr_rmw
    import cpu_pkg::*;
(
    input  logic [3:0]  csr_cmd_i,
    input  logic [31:0] csr_rdata_i,
    input  logic [31:0] op1_data_i,
    output logic [31:0] csr_wdata_o
);

    // The E bit is only an ecall marker and never produces a write value
    logic unusedEcall;
    assign unusedEcall = csr_cmd_i[CSR_E];

    // Write, set-bits and clear-bits forms of the CSR update
    always_comb begin
        csr_wdata_o = '0;
        if (csr_cmd_i[CSR_W]) begin
            csr_wdata_o = op1_data_i;
        end else if (csr_cmd_i[CSR_S]) begin
            csr_wdata_o = csr_rdata_i | op1_data_i;
        end else if (csr_cmd_i[CSR_C]) begin
            csr_wdata_o = csr_rdata_i & ~op1_data_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access pipeline stage. Registers the execute bus under a
// valid/allowin handshake, issues stores through a request/acknowledge
// state machine, performs CSR read-modify-write and selects the
// write-back value.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   exe_mem_bus_in, es_to_ms_valid  incoming instruction and its valid
//   ms_allowin                      stage can accept a new instruction
//   ms_to_ws_valid, ws_allowin      downstream handshake
//   mem_wb_bus_out                  {wb_value, rd, rd_wen, pc}
//   mem_id_data_bus                 {wb_value, fwd_wen, rd} forwarding
//   dmem_we/waddr/wdata, dmem_wack  data-memory store port
//   csr_rdata                       CSR value read during execute
//   csr_we/waddr/wdata              CSR write port
//   misalign_exc                    misaligned access flag
// Optional feature: define MEM_ALIGN_CHECK_EN to enable the alignment check.
module mem_stage
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus_in,
    input  logic                     es_to_ms_valid,
    output logic                     ms_allowin,
    output logic                     ms_to_ws_valid,
    input  logic                     ws_allowin,
    output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus_out,
    output logic [MEM_ID_BUS_W-1:0]  mem_id_data_bus,
    output logic                     dmem_we,
    output logic [31:0]              dmem_waddr,
    output logic [31:0]              dmem_wdata,
    input  logic                     dmem_wack,
    input  logic [31:0]              csr_rdata,
    output logic                     csr_we,
    output logic [11:0]              csr_waddr,
    output logic [31:0]              csr_wdata,
    output logic                     misalign_exc
);

    exeMemBus_t  inBus;
    exeMemBus_t  memBus_q;
    logic        msValid_q;
    storeState_e state_q;
    logic        dmemWe_q;

    logic        readyGo;
    logic        capture;
    logic        fire;
    logic        storeStart;
    logic        misaligned;
    logic        inMisaligned;
    logic        rdWenEff;
    logic [31:0] wbValue;
    logic [31:0] csrWdata;

    assign inBus = exeMemBus_t'(exe_mem_bus_in);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned   = isMisaligned(memBus_q);
    assign inMisaligned = isMisaligned(inBus);
`else
    assign misaligned   = 1'b0;
    assign inMisaligned = 1'b0;
    logic unusedMemRe;
    assign unusedMemRe = memBus_q.mem_re;
`endif

    // A store may only leave once memory has taken it; in S_IDLE a held
    // store can only be a misaligned one that was never issued.
    always_comb begin
        readyGo = 1'b1;
        case (state_q)
            S_WREQ:  readyGo = dmem_wack;
            S_WDONE: readyGo = 1'b1;
            default: readyGo = !memBus_q.mem_we || misaligned;
        endcase
    end

    assign ms_allowin     = !msValid_q || (readyGo && ws_allowin);
    assign ms_to_ws_valid = msValid_q && readyGo;
    assign fire           = ms_to_ws_valid && ws_allowin;
    assign capture        = es_to_ms_valid && ms_allowin;
    assign storeStart     = capture && inBus.mem_we && !inMisaligned;

    // Pipeline valid and bus registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msValid_q <= 1'b0;
            memBus_q  <= '0;
        end else begin
            if (ms_allowin) begin
                msValid_q <= es_to_ms_valid;
            end
            if (capture) begin
                memBus_q <= inBus;
            end
        end
    end

    // Store request FSM. S_WDONE remembers that the store was already
    // accepted so a stalled instruction never re-issues it; a store
    // captured in the same cycle the previous one fires goes straight
    // back to S_WREQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dmemWe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (storeStart) begin
                        state_q  <= S_WREQ;
                        dmemWe_q <= 1'b1;
                    end
                end
                S_WREQ: begin
                    if (dmem_wack) begin
                        if (fire) begin
                            state_q  <= storeStart ? S_WREQ : S_IDLE;
                            dmemWe_q <= storeStart;
                        end else begin
                            state_q  <= S_WDONE;
                            dmemWe_q <= 1'b0;
                        end
                    end
                end
                S_WDONE: begin
                    if (fire) begin
                        state_q  <= storeStart ? S_WREQ : S_IDLE;
                        dmemWe_q <= storeStart;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    dmemWe_q <= 1'b0;
                end
            endcase
        end
    end

    // Write-back value selection
    always_comb begin
        wbValue = '0;
        case (memBus_q.wb_sel)
            WB_ALU:  wbValue = memBus_q.alu_result;
            WB_MEM:  wbValue = memBus_q.mem_rd_data;
            WB_PC4:  wbValue = memBus_q.pc + 32'd4;
            WB_CSR:  wbValue = csr_rdata;
            default: wbValue = '0;
        endcase
    end

    csr_rmw u_csr_rmw (
        .csr_cmd_i   (memBus_q.csr_cmd),
        .csr_rdata_i (csr_rdata),
        .op1_data_i  (memBus_q.op1_data),
        .csr_wdata_o (csrWdata)
    );

    assign rdWenEff = memBus_q.rd_wen && !misaligned;

    assign mem_wb_bus_out  = {wbValue, memBus_q.rd, rdWenEff && ms_to_ws_valid, memBus_q.pc};
    assign mem_id_data_bus = {wbValue, msValid_q && rdWenEff, memBus_q.rd};

    assign dmem_we    = dmemWe_q;
    assign dmem_waddr = memBus_q.alu_result;
    assign dmem_wdata = memBus_q.wb_data;

    assign csr_we    = fire && (|memBus_q.csr_cmd[3:1]);
    assign csr_waddr = memBus_q.csr_addr;
    assign csr_wdata = csrWdata;

    assign misalign_exc = fire && misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed self-checking bench for mem_stage. Inputs change one time unit
// after a rising edge; outputs are sampled on the falling edge.
// Optional feature macro exercised when defined: MEM_ALIGN_CHECK_EN.
module tb_mem_stage;

    logic         clk;
    logic         rst_n;
    logic [186:0] exe_mem_bus_in;
    logic         es_to_ms_valid;
    logic         ms_allowin;
    logic         ms_to_ws_valid;
    logic         ws_allowin;
    logic [69:0]  mem_wb_bus_out;
    logic [37:0]  mem_id_data_bus;
    logic         dmem_we;
    logic [31:0]  dmem_waddr;
    logic [31:0]  dmem_wdata;
    logic         dmem_wack;
    logic [31:0]  csr_rdata;
    logic         csr_we;
    logic [11:0]  csr_waddr;
    logic [31:0]  csr_wdata;
    logic         misalign_exc;

    int total = 0;
    int bad   = 0;
    int writeCount = 0;
    int csrStrobeCount = 0;
    int snap;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exe_mem_bus_in  (exe_mem_bus_in),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ws_allowin      (ws_allowin),
        .mem_wb_bus_out  (mem_wb_bus_out),
        .mem_id_data_bus (mem_id_data_bus),
        .dmem_we         (dmem_we),
        .dmem_waddr      (dmem_waddr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wack       (dmem_wack),
        .csr_rdata       (csr_rdata),
        .csr_we          (csr_we),
        .csr_waddr       (csr_waddr),
        .csr_wdata       (csr_wdata),
        .misalign_exc    (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted stores and CSR strobes at each active edge
    always @(posedge clk) begin
        if (rst_n && dmem_we && dmem_wack) writeCount++;
        if (rst_n && csr_we) csrStrobeCount++;
    end

    function automatic logic [186:0] makeBus(
        input logic [31:0] alu, input logic [4:0] rd, input logic rdWen,
        input logic memWe, input logic memRe, input logic [2:0] wbSel,
        input logic [31:0] pc, input logic [31:0] wbData, input logic [3:0] csrCmd,
        input logic [11:0] csrAddr, input logic [31:0] op1, input logic [31:0] memRd);
        return {alu, rd, rdWen, memWe, memRe, wbSel, pc, wbData, csrCmd, csrAddr, op1, memRd};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    // Present one instruction for a single capture edge, then withdraw it
    task automatic applyStimulus(input logic [186:0] bus);
        exe_mem_bus_in = bus;
        es_to_ms_valid = 1'b1;
        nextCycle();
        es_to_ms_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        exe_mem_bus_in = '0;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        dmem_wack      = 1'b0;
        csr_rdata      = '0;

        // Reset state
        atNeg();
        checkOutput("rst_allowin", ms_allowin, 1'b1);
        checkOutput("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        checkOutput("rst_dmem_we", dmem_we, 1'b0);
        checkOutput("rst_csr_we", csr_we, 1'b0);
        checkOutput("rst_misalign", misalign_exc, 1'b0);
        checkOutput("rst_wb_bus", mem_wb_bus_out, 70'd0);
        checkOutput("rst_id_bus", mem_id_data_bus, 38'd0);
        nextCycle();
        rst_n = 1'b1;

        // ALU result, one cycle latency, forwarding valid while held
        applyStimulus(makeBus(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1000, 32'h0, 4'h0, 12'h0, 32'h0, 32'h0));
        atNeg();
        checkOutput("alu_to_ws_valid", ms_to_ws_valid, 1'b1);
        checkOutput("alu_wb_bus", mem_wb_bus_out, {32'h1234, 5'd5, 1'b1, 32'h1000});
        checkOutput("alu_id_bus", mem_id_data_bus, {32'h1234, 1'b1, 5'd5});
        nextCycle();
        atNeg();
        checkOutput("alu_drained", ms_to_ws_valid, 1'b0);
        checkOutput("alu_fwd_off", mem_id_data_bus[5], 1'b0);
        nextCycle();

        // Store with the acknowledge arriving in the third request cycle
        snap = writeCount;
        applyStimulus(makeBus(32'h100, 5'd9, 1'b1, 1'b1, 1'b0, 3'd0, 32'h2000, 32'hDEADBEEF, 4'h0, 12'h0, 32'h0, 32'h0));
        atNeg();
        checkOutput("st1_we_c1", dmem_we, 1'b1);
        checkOutput("st1_waddr", dmem_waddr, 32'h100);
        checkOutput("st1_wdata", dmem_wdata, 32'hDEADBEEF);
        checkOutput("st1_allowin_c1", ms_allowin, 1'b0);
        checkOutput("st1_valid_c1", ms_to_ws_valid, 1'b0);
        checkOutput("st1_rdwen_gated", mem_wb_bus_out[32], 1'b0);
        checkOutput("st1_fwd_wen", mem_id_data_bus[5], 1'b1);
        nextCycle();
        atNeg();
        checkOutput("st1_we_c2", dmem_we, 1'b1);
        checkOutput("st1_allowin_c2", ms_allowin, 1'b0);
        checkOutput("st1_waddr_c2", dmem_waddr, 32'h100);
        nextCycle();
        dmem_wack = 1'b1;
        atNeg();
        checkOutput("st1_we_c3", dmem_we, 1'b1);
        checkOutput("st1_valid_c3", ms_to_ws_valid, 1'b1);
        checkOutput("st1_allowin_c3", ms_allowin, 1'b1);
        nextCycle();
        dmem_wack = 1'b0;
        atNeg();
        checkOutput("st1_we_done", dmem_we, 1'b0);
        checkOutput("st1_drained", ms_to_ws_valid, 1'b0);
        checkOutput("st1_writes", writeCount - snap, 1);
        nextCycle();

        // Store acknowledged while write-back stalls for two cycles
        snap = writeCount;
        applyStimulus(makeBus(32'h200, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h3000, 32'h55, 4'h0, 12'h0, 32'h0, 32'h0));
        ws_allowin = 1'b0;
        dmem_wack  = 1'b1;
        atNeg();
        checkOutput("st2_we_ack", dmem_we, 1'b1);
        checkOutput("st2_allowin_stall", ms_allowin, 1'b0);
        nextCycle();
        dmem_wack = 1'b0;
        atNeg();
        checkOutput("st2_we_wdone", dmem_we, 1'b0);
        checkOutput("st2_valid_wdone", ms_to_ws_valid, 1'b1);
        checkOutput("st2_allowin_wdone", ms_allowin, 1'b0);
        nextCycle();
        dmem_wack = 1'b1;
        atNeg();
        checkOutput("st2_stray_ack", dmem_we, 1'b0);
        nextCycle();
        dmem_wack  = 1'b0;
        ws_allowin = 1'b1;
        atNeg();
        checkOutput("st2_release", ms_allowin, 1'b1);
        checkOutput("st2_no_reissue", dmem_we, 1'b0);
        nextCycle();
        atNeg();
        checkOutput("st2_drained", ms_to_ws_valid, 1'b0);
        checkOutput("st2_writes", writeCount - snap, 1);
        nextCycle();

        // Back-to-back stores with zero-wait memory
        snap = writeCount;
        applyStimulus(makeBus(32'h300, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h11, 4'h0, 12'h0, 32'h0, 32'h0));
        exe_mem_bus_in = makeBus(32'h304, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h22, 4'h0, 12'h0, 32'h0, 32'h0);
        es_to_ms_valid = 1'b1;
        dmem_wack      = 1'b1;
        atNeg();
        checkOutput("b2b_first_addr", dmem_waddr, 32'h300);
        checkOutput("b2b_first_allowin", ms_allowin, 1'b1);
        nextCycle();
        es_to_ms_valid = 1'b0;
        dmem_wack      = 1'b0;
        atNeg();
        checkOutput("b2b_second_we", dmem_we, 1'b1);
        checkOutput("b2b_second_addr", dmem_waddr, 32'h304);
        checkOutput("b2b_second_data", dmem_wdata, 32'h22);
        nextCycle();
        dmem_wack = 1'b1;
        atNeg();
        checkOutput("b2b_second_valid", ms_to_ws_valid, 1'b1);
        nextCycle();
        dmem_wack = 1'b0;
        atNeg();
        checkOutput("b2b_idle_we", dmem_we, 1'b0);
        checkOutput("b2b_writes", writeCount - snap, 2);
        nextCycle();

        // CSR set with one stall cycle, then clear and write forms
        snap = csrStrobeCount;
        csr_rdata = 32'hF0;
        applyStimulus(makeBus(32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd3, 32'h4000, 32'h0, 4'b0100, 12'h300, 32'h0F, 32'h0));
        ws_allowin = 1'b0;
        atNeg();
        checkOutput("csr_we_stall", csr_we, 1'b0);
        checkOutput("csr_wdata_set", csr_wdata, 32'hFF);
        checkOutput("csr_waddr", csr_waddr, 12'h300);
        nextCycle();
        ws_allowin = 1'b1;
        atNeg();
        checkOutput("csr_we_fire", csr_we, 1'b1);
        checkOutput("csr_wb_value", mem_wb_bus_out[69:38], 32'hF0);
        nextCycle();
        atNeg();
        checkOutput("csr_we_after", csr_we, 1'b0);
        checkOutput("csr_strobes", csrStrobeCount - snap, 1);
        nextCycle();
        csr_rdata = 32'hFF;
        applyStimulus(makeBus(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'b0010, 12'h305, 32'h0F, 32'h0));
        atNeg();
        checkOutput("csr_wdata_clear", csr_wdata, 32'hF0);
        nextCycle();
        applyStimulus(makeBus(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'b1000, 12'h341, 32'h0F, 32'h0));
        atNeg();
        checkOutput("csr_wdata_write", csr_wdata, 32'h0F);
        nextCycle();
        applyStimulus(makeBus(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'b0001, 12'h0, 32'h0F, 32'h0));
        atNeg();
        checkOutput("csr_ecall_no_we", csr_we, 1'b0);
        nextCycle();

        // Write-back selects: PC+4 wrap, memory data, unused code
        applyStimulus(makeBus(32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 4'h0, 12'h0, 32'h0, 32'h0));
        atNeg();
        checkOutput("jal_wb_bus", mem_wb_bus_out, {32'h0, 5'd1, 1'b1, 32'hFFFFFFFC});
        nextCycle();
        applyStimulus(makeBus(32'h8, 5'd3, 1'b1, 1'b0, 1'b1, 3'd1, 32'h10, 32'h0, 4'h0, 12'h0, 32'h0, 32'hCAFEF00D));
        atNeg();
        checkOutput("load_wb_value", mem_wb_bus_out[69:38], 32'hCAFEF00D);
        nextCycle();
        applyStimulus(makeBus(32'h77, 5'd3, 1'b1, 1'b0, 1'b0, 3'd5, 32'h10, 32'h0, 4'h0, 12'h0, 32'h0, 32'h1));
        atNeg();
        checkOutput("bad_sel_zero", mem_id_data_bus[37:6], 32'h0);
        nextCycle();

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned store is never issued and flags the exception
        snap = writeCount;
        applyStimulus(makeBus(32'h102, 5'd4, 1'b1, 1'b1, 1'b0, 3'd0, 32'h20, 32'h9, 4'h0, 12'h0, 32'h0, 32'h0));
        atNeg();
        checkOutput("mis_we", dmem_we, 1'b0);
        checkOutput("mis_exc", misalign_exc, 1'b1);
        checkOutput("mis_rdwen", mem_wb_bus_out[32], 1'b0);
        nextCycle();
        atNeg();
        checkOutput("mis_exc_after", misalign_exc, 1'b0);
        checkOutput("mis_writes", writeCount - snap, 0);
        nextCycle();
`endif

        // Reset during a pending store drops the request immediately
        applyStimulus(makeBus(32'h400, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h1, 4'h0, 12'h0, 32'h0, 32'h0));
        atNeg();
        checkOutput("rstmid_we_before", dmem_we, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_we_dropped", dmem_we, 1'b0);
        checkOutput("rstmid_allowin", ms_allowin, 1'b1);
        checkOutput("rstmid_valid", ms_to_ws_valid, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        atNeg();
        checkOutput("rstmid_stays_idle", dmem_we, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that directly consumes the execute stage's 187-bit `exe_mem_bus_out`. It registers the bus under a valid/allowin handshake and drives the data-memory write port through a request/acknowledge state machine. It also performs CSR read-modify-write and selects the write-back value. Its outputs are the 70-bit bus to write-back and the 38-bit forwarding bus to decode.

## Interface
Parameters:
- none (all widths fixed by the shared package)

Ports:
- `clk`  in  1  sole clock; all state on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `exe_mem_bus_in`  in  187  `{alu_result[31:0], rd[4:0], rd_wen, mem_we, mem_re, wb_sel[2:0], pc[31:0], wb_data[31:0], csr_cmd[3:0], csr_addr[11:0], op1_data[31:0], mem_rd_data[31:0]}`
- `es_to_ms_valid`  in  1  upstream valid
- `ms_allowin`  out  1  stage can accept
- `ms_to_ws_valid`  out  1  downstream valid
- `ws_allowin`  in  1  write-back can accept
- `mem_wb_bus_out`  out  70  `{wb_value[31:0], rd[4:0], rd_wen, pc[31:0]}`
- `mem_id_data_bus`  out  38  `{wb_value[31:0], fwd_wen, rd[4:0]}`; `fwd_wen` = `ms_valid & rd_wen`
- `dmem_we`  out  1  store request; held until acknowledged
- `dmem_waddr`  out  32  `alu_result`
- `dmem_wdata`  out  32  `wb_data`
- `dmem_wack`  in  1  store accepted this cycle
- `csr_rdata`  in  32  CSR value read in the execute cycle (file addressed by execute's `csr_raddr`)
- `csr_we`  out  1  CSR write strobe, one cycle at fire
- `csr_waddr`  out  12  `csr_addr`
- `csr_wdata`  out  32  computed CSR value
- `misalign_exc`  out  1  misaligned access flag (see Configuration)

## Operation
- Pipeline register `ms_valid` and bus register `bus_r`. Both are loaded when `es_to_ms_valid && ms_allowin`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- Fire means `ms_to_ws_valid && ws_allowin`.
- Store FSM states: S_IDLE, S_WREQ, S_WDONE.
  - S_IDLE → S_WREQ on capture of an instruction with `mem_we=1`.
  - S_WREQ: `dmem_we=1`. On `dmem_wack`: go to S_IDLE if fire in the same cycle, else to S_WDONE.
  - S_WDONE: `dmem_we=0`. Go to S_IDLE on fire. This state prevents a re-issued store while stalled.
- `ms_ready_go`: 1 if `!mem_we`; in S_WREQ it equals `dmem_wack`; 1 in S_WDONE.
- A back-to-back store captured on the same cycle as fire goes directly to S_WREQ.
- `wb_sel` (package encoding): WB_ALU=0 → `alu_result`; WB_MEM=1 → `mem_rd_data`; WB_PC4=2 → `pc+4` (mod 2^32); WB_CSR=3 → `csr_rdata`; others → 0.
- `csr_cmd` is one-hot:
  - bit3 W: `wdata=op1_data`
  - bit2 S: `wdata=csr_rdata|op1_data`
  - bit1 C: `wdata=csr_rdata&~op1_data`
  - bit0 E: no CSR write; passed through as the ecall marker.
- `csr_we = fire && |csr_cmd[3:1]`.
- `rd_wen` in `mem_wb_bus_out` is forced to 0 when `!ms_to_ws_valid`.

## Timing
- Reset values: `ms_valid=0`, `ms_allowin=1`, `ms_to_ws_valid=0`, FSM=S_IDLE, `dmem_we=0`, `csr_we=0`, `misalign_exc=0`, `bus_r=0`.
- Latency for non-store instructions: 1 cycle, i.e. captured at edge N, fires at edge N+1 if `ws_allowin`.
- Store latency: 1 + number of wait cycles until `dmem_wack`. Zero-wait memory (ack in the first S_WREQ cycle) gives 1 cycle.
- `dmem_we`, `dmem_waddr` and `dmem_wdata` stay stable from S_WREQ entry until `dmem_wack`.
- Reset mid-store drops the request asynchronously. No acknowledge is expected afterwards.
- `dmem_wack` outside S_WREQ is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: when `(mem_we||mem_re) && alu_result[1:0]!=0`:
  - the FSM skips S_WREQ (no store issued);
  - `rd_wen` is cleared;
  - `misalign_exc=1` for the fire cycle.
- Not defined: no check is made; `misalign_exc` is tied 0 and the address is passed unmodified.

## Structure
- Shared package (`cpu_pkg`): bus widths (187/70/38), `WB_*` codes, `CSR_W/S/C/E` bit indices, FSM state enum.
- One sub-module, `csr_rmw`: combinational CSR write-data computation from `csr_cmd`, `csr_rdata` and `op1_data`.

## Test plan
- ALU op: `alu_result=0x1234`, `rd=5`, `rd_wen=1`, WB_ALU → `mem_wb_bus_out={0x1234,5,1,pc}` one cycle later; forwarding bus is valid the same cycle.
- Store with `dmem_wack` delayed 3 cycles, addr `0x100`, data `0xDEADBEEF` → `dmem_we` high for exactly 3 cycles, `ms_allowin=0` meanwhile, a single write.
- Store acked while `ws_allowin=0` for 2 cycles → FSM goes to S_WDONE, `dmem_we` drops after the ack, no second request, fires when `ws_allowin` rises.
- CSR set: `csr_rdata=0xF0`, `op1_data=0x0F`, `csr_cmd=0100` → `csr_we` one cycle, `csr_wdata=0xFF`, `csr_waddr` matches; a stall produces no extra strobe.
- JAL write-back: `pc=0xFFFFFFFC`, WB_PC4 → `wb_value=0x00000000`.
- With `MEM_ALIGN_CHECK_EN`: store to `0x102` → no `dmem_we`, `misalign_exc=1`, `rd_wen=0`. Assert `rst_n` low during S_WREQ → `dmem_we=0` immediately.
